// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its enable/done handshake; all outputs registered.
// Optional sticky dropped-write flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    tx_data,
  output logic          tx_enable,
  input  logic          tx_done,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          pop;
  logic [CW-1:0] count_next;

  // full is the registered flag, so a write in the pop cycle of a full FIFO is dropped
  assign wr_acc = wr_en && !full;
  assign pop    = (state == IDLE) && !empty;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!empty) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (!tx_done) state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    unique case ({wr_acc, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      tx_data   <= 8'h00;
      tx_enable <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      full      <= (count_next == CW'(DEPTH));
      empty     <= (count_next == '0);
      tx_enable <= (state_next == LAUNCH);
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (reset)              overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table for the single-byte path, loops for multi-frame cases.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;
  logic          tx_enable;
  logic          tx_done = 1'b0;
  logic          overflow;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef UART_TX_FIFO_OVF_EN
  localparam int OVF_EXP = 1;
`else
  localparam int OVF_EXP = 0;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .tx_data   (tx_data),
    .tx_enable (tx_enable),
    .tx_done   (tx_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst;
    logic          we;
    logic [7:0]    wd;
    logic          dn;
    logic [CW-1:0] cnt;
    logic          emp;
    logic          ful;
    logic          en;
    logic [7:0]    td;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    int last_en;
    int last_done;
    int low_from;
    int high_at;

    // single byte 8'h41 written with tx_done low, then one done pulse
    vecs[0] = '{rst:1'b1, we:1'b0, wd:8'h00, dn:1'b0, cnt:5'd0, emp:1'b1, ful:1'b0, en:1'b0, td:8'h00};
    vecs[1] = '{rst:1'b0, we:1'b1, wd:8'h41, dn:1'b0, cnt:5'd1, emp:1'b0, ful:1'b0, en:1'b0, td:8'h00};
    vecs[2] = '{rst:1'b0, we:1'b0, wd:8'h00, dn:1'b0, cnt:5'd0, emp:1'b1, ful:1'b0, en:1'b1, td:8'h41};
    vecs[3] = '{rst:1'b0, we:1'b0, wd:8'h00, dn:1'b0, cnt:5'd0, emp:1'b1, ful:1'b0, en:1'b0, td:8'h41};
    vecs[4] = '{rst:1'b0, we:1'b0, wd:8'h00, dn:1'b0, cnt:5'd0, emp:1'b1, ful:1'b0, en:1'b0, td:8'h41};
    vecs[5] = '{rst:1'b0, we:1'b0, wd:8'h00, dn:1'b1, cnt:5'd0, emp:1'b1, ful:1'b0, en:1'b0, td:8'h41};
    vecs[6] = '{rst:1'b0, we:1'b0, wd:8'h00, dn:1'b1, cnt:5'd0, emp:1'b1, ful:1'b0, en:1'b0, td:8'h41};

    for (int i = 0; i < 7; i++) begin
      reset   = vecs[i].rst;
      wr_en   = vecs[i].we;
      wr_data = vecs[i].wd;
      tx_done = vecs[i].dn;
      tick();
      chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].cnt));
      chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].emp));
      chk($sformatf("v%0d_full", i), int'(full), int'(vecs[i].ful));
      chk($sformatf("v%0d_tx_enable", i), int'(tx_enable), int'(vecs[i].en));
      chk($sformatf("v%0d_tx_data", i), int'(tx_data), int'(vecs[i].td));
      if (i == 0) chk("v0_overflow", int'(overflow), 0);
    end
    tx_done = 1'b0;
    tick();

    // burst of three, transmitter pulses done 20 cycles after each enable
    n = 0; last_en = -1000; last_done = -1000;
    for (int c = 0; c < 120; c++) begin
      if (tx_enable) begin
        chk("s2_order", int'(tx_data), 8'h31 + n);
        if (n > 0) chk("s2_gap", c - last_done, 2);
        last_en = c;
        n++;
      end
      wr_en   = (c < 3);
      wr_data = 8'h31 + c[7:0];
      tx_done = (c == last_en + 20);
      if (tx_done) last_done = c;
      tick();
    end
    wr_en = 1'b0;
    chk("s2_launches", n, 3);
    chk("s2_empty", int'(empty), 1);

    // level-style done: high between frames, low for 10 cycles starting 1 after enable
    n = 0; low_from = 1000000; high_at = 1000000;
    for (int c = 0; c < 100; c++) begin
      if (tx_enable) begin
        chk("s3_order", int'(tx_data), 8'h51 + n);
        low_from = c + 1;
        high_at  = c + 11;
        n++;
      end
      wr_en   = (c < 4);
      wr_data = 8'h51 + c[7:0];
      tx_done = !(c >= low_from && c < high_at);
      tick();
    end
    wr_en = 1'b0;
    chk("s3_launches", n, 4);
    chk("s3_empty", int'(empty), 1);

    // stalled transmitter, fill to full and overflow
    reset = 1'b1; tx_done = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 17; c++) begin
      wr_en   = 1'b1;
      wr_data = c[7:0];
      tick();
    end
    chk("s4_count_full", int'(count), 16);
    chk("s4_full", int'(full), 1);
    chk("s4_inflight", int'(tx_data), 8'h00);
    chk("s4_ovf_before", int'(overflow), 0);
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("s4_count_drop", int'(count), 16);
    chk("s4_full_drop", int'(full), 1);
    chk("s4_overflow", int'(overflow), OVF_EXP);
    chk("s4_no_enable", int'(tx_enable), 0);

    // done pulse, write 8'hAA in the pop cycle (dropped), then drain across the wrap
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0; wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("s5_pop_enable", int'(tx_enable), 1);
    chk("s5_pop_count", int'(count), 15);
    chk("s5_pop_full", int'(full), 0);
    n = 0; last_en = -1000;
    for (int c = 0; c < 140; c++) begin
      if (tx_enable) begin
        chk("s5_order", int'(tx_data), 8'h01 + n);
        last_en = c;
        n++;
      end
      tx_done = (c == last_en + 5);
      tick();
    end
    tx_done = 1'b0;
    chk("s5_launches", n, 16);
    chk("s5_empty", int'(empty), 1);
    chk("s5_count", int'(count), 0);
    chk("s5_overflow_sticky", int'(overflow), OVF_EXP);

    // reset while in WAIT_DONE with five bytes queued
    for (int c = 0; c < 6; c++) begin
      wr_en   = 1'b1;
      wr_data = 8'h60 + c[7:0];
      tick();
    end
    wr_en = 1'b0;
    chk("s6_queued", int'(count), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_count", int'(count), 0);
    chk("s6_empty", int'(empty), 1);
    chk("s6_tx_enable", int'(tx_enable), 0);
    chk("s6_tx_data", int'(tx_data), 8'h00);
    chk("s6_overflow", int'(overflow), 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (tx_enable) n++;
      tick();
    end
    chk("s6_no_relaunch", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch sequencer placed directly upstream of the UART transmitter. It accepts bytes from any producer (button logic, echo path, message ROM) through a single-cycle write strobe and stores them in a circular FIFO. It then feeds them one at a time to the transmitter using that block's `enable`/`done` handshake. Producers can queue bursts without tracking transmitter state.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `CW`, `$clog2(DEPTH+1)`: width of `count`; derived, never overridden.

Ports:
- `clk`, in, 1: sole clock; all state on `posedge clk`.
- `reset`, in, 1: synchronous, active-high.
- `wr_en`, in, 1: write strobe; one byte per high cycle.
- `wr_data`, in, 8: byte to enqueue; sampled when `wr_en` is high.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.
- `count`, out, CW: bytes currently stored; excludes the byte in flight.
- `tx_data`, out, 8: byte presented to the transmitter's `data_to_send`; held stable until the next launch.
- `tx_enable`, out, 1: one-cycle launch pulse to the transmitter's `enable`.
- `tx_done`, in, 1: transmitter's `done`; pulse or level accepted.
- `overflow`, out, 1: sticky dropped-write flag (see Configuration).

## Operation
- Storage: `DEPTH`×8 array; `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
- Write: if `wr_en` and `!full` (registered `count`), store the byte at `wr_ptr` and increment `wr_ptr`.
  - A write while full is dropped, even if a pop occurs in the same cycle.
- Pop: happens only in IDLE with `!empty`. Latch `mem[rd_ptr]` into `tx_data` and increment `rd_ptr`.
- Simultaneous accepted write and pop: `count` unchanged; both pointers advance.
- FSM states and transitions:
  - IDLE: if `!empty`, pop and go to LAUNCH; otherwise stay.
  - LAUNCH: `tx_enable` = 1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_done` == 0, which discards a stale level-style done, then go to WAIT_DONE.
  - WAIT_DONE: on `tx_done` == 1, go to IDLE.
  - `tx_done` is ignored in IDLE and LAUNCH.
- Reset values:
  - Pointers 0, `count` 0, `empty` 1, `full` 0.
  - `tx_data` 8'h00, `tx_enable` 0, `overflow` 0, state IDLE.
- Reset mid-transmission: all queued bytes are discarded and the FSM returns to IDLE. A frame the transmitter has already started is not aborted; the block does not relaunch it.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Write to an empty FIFO in IDLE at cycle N:
  - `count` = 1 and `empty` = 0 at N+1.
  - Pop at N+1; `count` = 0 at N+2.
  - `tx_data` valid and `tx_enable` = 1 at N+2.
- Back-to-back: the next `tx_enable` follows at the earliest 2 cycles after the cycle `tx_done` is seen high in WAIT_DONE (return to IDLE, then LAUNCH).
- Throughput: at most one byte per transmitter frame. The FIFO absorbs up to `DEPTH` bytes beyond the byte in flight.
- `full` and `overflow` update one cycle after the causing `wr_en`.

## Configuration
- `UART_TX_FIFO_OVF_EN`:
  - Defined: `overflow` is set on the cycle after any write attempted while `full`. It stays at 1 until `reset`.
  - Undefined: `overflow` is tied to 0, no flag register exists, and dropped writes are silent. All other behaviour is identical.

## Test plan
- Reset, then write 8'h41 at cycle N with `tx_done` held 0 → `tx_enable` high only at N+2 with `tx_data` = 8'h41; `count` returns to 0; no second pulse until `tx_done` pulses.
- Write 8'h31, 8'h32, 8'h33 on consecutive cycles; model transmitter pulses `tx_done` 20 cycles after each enable → three enables in order 31, 32, 33, each 2 cycles after the preceding `tx_done`; `empty` = 1 at the end.
- Level-style done: `tx_done` stays high between frames and drops 1 cycle after enable → every byte is launched exactly once; no launch triggered by a stale done.
- Stall the transmitter; write 17 bytes 8'h00–8'h10 with `DEPTH` = 16 → first byte in flight, `count` = 16, `full` = 1; write 8'h10 accepted; an 18th write is dropped and `overflow` = 1 (macro defined) or 0 (undefined).
- Fill to 16 while stalled; pulse `tx_done` and write 8'hAA in the pop cycle → write dropped; subsequent drain order intact across pointer wrap.
- Assert `reset` while in WAIT_DONE with 5 bytes queued → next cycle `count` = 0, `tx_enable` = 0, `tx_data` = 8'h00, `overflow` = 0; the following `tx_done` causes no launch.
